// File: rtl/seg_scan_capture.sv
// Reads back the multiplexed active-low 7-segment bus, waits for each digit's
// dwell to settle, and decodes it to BCD. Optional macro SEG_DP_EN adds dp/dp_out.
module seg_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
`ifdef SEG_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    capture_stb,
  output logic                    frame_valid,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HELD = 2'd2} state_t;

  state_t                  state, state_next;
  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [7:0]              cnt, cnt_next;
  logic [NUM_DIGITS-1:0]   mask, mask_set;
  logic                    sel, same, dp_same, capture, frame_done;
  logic [2:0]              sel_idx;
  logic [3:0]              nzero;
  logic [4:0]              dec;

`ifdef SEG_DP_EN
  logic dp_q, dp_p;
  assign dp_same = (dp_q == dp_p);
`else
  assign dp_same = 1'b1;
`endif

  // Returns {err, bcd}; all-dark is a legitimate blank, anything unknown is 'E'.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  always_comb begin
    nzero      = '0;
    sel_idx    = '0;
    mask_set   = mask;
    state_next = state;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        nzero   = nzero + 4'd1;
        sel_idx = 3'(i);
      end
    end
    sel  = (nzero == 4'd1);
    // an_q == an_p together with sel means the same single digit is still driven.
    same = sel && (seg_q == seg_p) && (an_q == an_p) && dp_same;
    if (!sel)      cnt_next = 8'd0;
    else if (same) cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    else           cnt_next = 8'd1;
    capture = (state == TRACK) && same && (cnt_next == 8'(STABLE_CYCLES));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_idx == 3'(i)) mask_set[i] = 1'b1;
    end
    frame_done = capture && (&mask_set);
    dec        = decode(seg_q);
    case (state)
      IDLE:    if (sel) state_next = TRACK;
      TRACK:   if (!sel) state_next = IDLE;
               else if (capture) state_next = HELD;
      HELD:    if (!sel) state_next = IDLE;
               else if (!same) state_next = TRACK;
      default: state_next = IDLE;
    endcase
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '1;
      seg_p       <= '1;
      an_q        <= '1;
      an_p        <= '1;
      cnt         <= 8'd0;
      state       <= IDLE;
      mask        <= '0;
      digits      <= '1;
      digit_err   <= '0;
      capture_stb <= 1'b0;
      frame_valid <= 1'b0;
`ifdef SEG_DP_EN
      dp_q        <= 1'b1;
      dp_p        <= 1'b1;
      dp_out      <= '0;
`endif
    end else begin
      seg_q       <= seg;
      an_q        <= an;
      seg_p       <= seg_q;
      an_p        <= an_q;
      cnt         <= cnt_next;
      state       <= state_next;
      capture_stb <= capture;
      frame_valid <= frame_done;
`ifdef SEG_DP_EN
      dp_q        <= dp;
      dp_p        <= dp_q;
`endif
      if (capture) begin
        mask <= frame_done ? '0 : mask_set;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_idx == 3'(i)) begin
            digits[4*i +: 4] <= dec[3:0];
            digit_err[i]     <= dec[4];
`ifdef SEG_DP_EN
            dp_out[i]        <= ~dp_q;
`endif
          end
        end
      end
    end
  end

endmodule
